ua_channel_sched: RTL and testbench

UA_CHANNEL_SCHED -- requirements
Module: ua_channel_sched

---
 rtl/ua_sched_pkg.sv | 21 ++
 rtl/ua_channel_sched_rr_arbiter.sv | 40 ++++
 rtl/ua_channel_sched.sv | 184 ++++++++++++++++++
 tb/tb_ua_channel_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ua_sched_pkg.sv
// ---------------------------------------------------------------------------
// ua_sched_pkg
// Shared definitions for the analog-pad channel scheduler: default sizes,
// the pad-index field width and the scheduler state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package ua_sched_pkg;

    localparam int N_REQ_DEF = 4;  // requesters sharing the pads
    localparam int N_PAD_DEF = 6;  // usable analog pads ua[5:0]
    localparam int CNT_W_DEF = 8;  // settle counter width
    localparam int PAD_W     = 3;  // bits per requester pad index

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONNECT = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_BREAK   = 2'd3
    } state_e;

endpackage

// File: rtl/ua_channel_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: searches req_mask starting at index ptr,
// wrapping, and returns the first set index. The pointer register lives in
// the parent.
// Ports:
//   req_mask [N]   candidate mask
//   ptr      [PW]  first index to consider
//   found          at least one candidate present
//   idx      [PW]  winning index (0 when found=0)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_mask,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req_mask[j]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/ua_channel_sched.sv
// ---------------------------------------------------------------------------
// ua_channel_sched
// Grants one requester at a time exclusive use of an analog pad, with a
// settle delay after the switch closes and a break-before-make dead time
// after it opens.
//
// Handshake: a requester raises req[i] (level) and holds it for as long as
// it needs the pad. gnt[i] and the pad switch close together; ready marks
// the settled sample window. Dropping req[i] (or ena) opens the switch on
// the next edge; the requester must not assume the pad afterwards.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ena               enable; low blocks grants and tears down a grant
//   req   [N_REQ]     per-requester level request
//   pad_idx[3*N_REQ]  requester i target pad at [3i+2:3i]
//   settle_cyc[CNT_W] settle time (CONNECT lasts settle_cyc+1 cycles)
//   dead_cyc [4]      dead time (BREAK lasts dead_cyc+1 cycles)
//   gnt   [N_REQ]     one-hot grant (registered)
//   sw_en [N_PAD]     one-hot switch enable (registered)
//   ready             sample window valid (ACTIVE only)
//   busy              state != IDLE
//   err_pad           pulse when an IDLE cycle sees a request with bad pad
// ---------------------------------------------------------------------------
module ua_channel_sched
    import ua_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int N_PAD = N_PAD_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*PAD_W-1:0] pad_idx,
    input  logic [CNT_W-1:0]       settle_cyc,
    input  logic [3:0]             dead_cyc,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_PAD-1:0]       sw_en,
    output logic                   ready,
    output logic                   busy,
    output logic                   err_pad
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      gnt_idx_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_PAD-1:0]   sw_en_q;
    logic               ready_q;
    logic               busy_q;
    logic               err_pad_q;

    logic [N_REQ-1:0]   valid_req;
    logic [N_REQ-1:0]   bad_req;
    logic               win_found;
    logic [PW-1:0]      win_idx;
    logic               bad_found;
    logic [PW-1:0]      bad_idx;
    logic [PAD_W-1:0]   win_pad;
    logic [N_REQ-1:0]   win_gnt;
    logic [N_PAD-1:0]   win_sw;

    // Split live requests into those with a usable pad and those without.
    always_comb begin
        valid_req = '0;
        bad_req   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            valid_req[i] = req[i] &&  (int'(pad_idx[PAD_W*i +: PAD_W]) < N_PAD);
            bad_req[i]   = req[i] && !(int'(pad_idx[PAD_W*i +: PAD_W]) < N_PAD);
        end
    end

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb_valid (
        .req_mask (valid_req),
        .ptr      (ptr_q),
        .found    (win_found),
        .idx      (win_idx)
    );

    // Second search over the bad requests so the pointer can step past a
    // requester that would otherwise sit at the head of the rotation.
    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb_bad (
        .req_mask (bad_req),
        .ptr      (ptr_q),
        .found    (bad_found),
        .idx      (bad_idx)
    );

    always_comb begin
        win_pad = '0;
        win_gnt = '0;
        win_sw  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_gnt[i] = (PW'(i) == win_idx);
            if (PW'(i) == win_idx) begin
                win_pad = pad_idx[PAD_W*i +: PAD_W];
            end
        end
        for (int p = 0; p < N_PAD; p++) begin
            win_sw[p] = (int'(win_pad) == p);
        end
    end

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] i);
        if (i == PTR_LAST) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_q     <= '0;
            sw_en_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_pad_q <= 1'b0;
        end else begin
            err_pad_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    err_pad_q <= |bad_req;
                    if (ena && win_found) begin
                        state_q   <= ST_CONNECT;
                        busy_q    <= 1'b1;
                        gnt_idx_q <= win_idx;
                        gnt_q     <= win_gnt;
                        sw_en_q   <= win_sw;
                        cnt_q     <= settle_cyc;
                        ptr_q     <= ptr_after(win_idx);
                    end else if (bad_found) begin
                        ptr_q <= ptr_after(bad_idx);
                    end
                end
                ST_CONNECT, ST_ACTIVE: begin
                    // Teardown wins over the settle countdown.
                    if (!ena || !req[gnt_idx_q]) begin
                        state_q <= ST_BREAK;
                        gnt_q   <= '0;
                        sw_en_q <= '0;
                        ready_q <= 1'b0;
                        cnt_q   <= CNT_W'(dead_cyc);
                    end else if (state_q == ST_CONNECT) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_ACTIVE;
                            ready_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign sw_en   = sw_en_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign err_pad = err_pad_q;

endmodule

// File: tb/tb_ua_channel_sched.sv
// ---------------------------------------------------------------------------
// tb_ua_channel_sched
// Directed scenarios for ua_channel_sched. The driver pushes the expected
// output word {gnt, sw_en, ready, busy, err_pad} for every cycle it drives;
// the monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_ua_channel_sched;

    localparam int W = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [11:0] pad_idx;
    logic [7:0]  settle_cyc;
    logic [3:0]  dead_cyc;
    logic [3:0]  gnt;
    logic [5:0]  sw_en;
    logic        ready;
    logic        busy;
    logic        err_pad;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    ua_channel_sched dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .req        (req),
        .pad_idx    (pad_idx),
        .settle_cyc (settle_cyc),
        .dead_cyc   (dead_cyc),
        .gnt        (gnt),
        .sw_en      (sw_en),
        .ready      (ready),
        .busy       (busy),
        .err_pad    (err_pad)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [W-1:0] mk(input logic [3:0] g, input logic [5:0] s,
                                        input logic r, input logic b, input logic e);
        return {g, s, r, b, e};
    endfunction

    task automatic set_pad(input int i, input logic [2:0] v);
        pad_idx[3*i +: 3] = v;
    endtask

    // Advance one edge and record what the outputs must be after it.
    task automatic step(input logic [W-1:0] e, input string nm);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One full grant from IDLE: CONNECT, ACTIVE, drop req, BREAK, IDLE.
    task automatic grant(input int who, input logic [5:0] sw, input int settle,
                         input int dead, input int n_act, input logic err1,
                         input logic reassert, input string nm);
        logic [3:0] g;
        g = 4'b0001 << who;
        for (int i = 0; i <= settle; i++)
            step(mk(g, sw, 1'b0, 1'b1, (i == 0) ? err1 : 1'b0), {nm, "_conn"});
        for (int i = 0; i < n_act; i++)
            step(mk(g, sw, 1'b1, 1'b1, 1'b0), {nm, "_act"});
        req[who] = 1'b0;
        for (int i = 0; i <= dead; i++)
            step(mk(4'b0, 6'b0, 1'b0, 1'b1, 1'b0), {nm, "_brk"});
        if (reassert) req[who] = 1'b1;
        step(mk(4'b0, 6'b0, 1'b0, 1'b0, 1'b0), {nm, "_idle"});
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] mon_e;
    string        mon_n;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            n_vec++;
            if ({gnt, sw_en, ready, busy, err_pad} !== mon_e) begin
                n_err++;
                $display("FAIL %s: got gnt=%b sw_en=%b ready=%b busy=%b err_pad=%b, want gnt=%b sw_en=%b ready=%b busy=%b err_pad=%b",
                         mon_n, gnt, sw_en, ready, busy, err_pad,
                         mon_e[12:9], mon_e[8:3], mon_e[2], mon_e[1], mon_e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        ena        = 1'b0;
        req        = 4'b0000;
        pad_idx    = '0;
        settle_cyc = 8'd0;
        dead_cyc   = 4'd0;
        for (int i = 0; i < 4; i++) set_pad(i, 3'(i));

        step(mk(4'b0, 6'b0, 0, 0, 0), "reset0");
        step(mk(4'b0, 6'b0, 0, 0, 0), "reset1");

        // Single grant: settle 3, dead 2, requester 1 on pad 4.
        settle_cyc = 8'd3;
        dead_cyc   = 4'd2;
        set_pad(1, 3'd4);
        req = 4'b0010;
        ena = 1'b1;
        rst = 1'b0;
        grant(1, 6'b010000, 3, 2, 2, 1'b0, 1'b0, "single");

        // Reset, then round robin 0,1,2,3,0 with everyone requesting.
        rst = 1'b1;
        step(mk(4'b0, 6'b0, 0, 0, 0), "reset2");
        rst = 1'b0;
        set_pad(1, 3'd1);
        settle_cyc = 8'd1;
        dead_cyc   = 4'd0;
        req = 4'b1111;
        grant(0, 6'b000001, 1, 0, 1, 1'b0, 1'b1, "rr0");
        grant(1, 6'b000010, 1, 0, 1, 1'b0, 1'b1, "rr1");
        grant(2, 6'b000100, 1, 0, 1, 1'b0, 1'b1, "rr2");
        grant(3, 6'b001000, 1, 0, 1, 1'b0, 1'b1, "rr3");
        grant(0, 6'b000001, 1, 0, 1, 1'b0, 1'b1, "rr4");

        // Bad pad on requester 2 is skipped and flagged.
        req = 4'b1100;
        set_pad(2, 3'd7);
        set_pad(3, 3'd0);
        grant(3, 6'b000001, 1, 0, 1, 1'b1, 1'b0, "badpad");
        step(mk(4'b0, 6'b0, 0, 0, 1), "badpad_err0");
        step(mk(4'b0, 6'b0, 0, 0, 1), "badpad_err1");
        req = 4'b0000;
        step(mk(4'b0, 6'b0, 0, 0, 0), "badpad_clr");
        set_pad(2, 3'd2);
        set_pad(3, 3'd3);

        // ena dropped in ACTIVE, then grants blocked while low.
        settle_cyc = 8'd0;
        dead_cyc   = 4'd1;
        req = 4'b0001;
        step(mk(4'b0001, 6'b000001, 0, 1, 0), "ena_conn");
        step(mk(4'b0001, 6'b000001, 1, 1, 0), "ena_act");
        ena = 1'b0;
        req = 4'b1111;
        step(mk(4'b0, 6'b0, 0, 1, 0), "ena_brk0");
        step(mk(4'b0, 6'b0, 0, 1, 0), "ena_brk1");
        for (int i = 0; i < 4; i++)
            step(mk(4'b0, 6'b0, 0, 0, 0), "ena_block");
        ena = 1'b1;
        settle_cyc = 8'd5;
        step(mk(4'b0010, 6'b000010, 0, 1, 0), "ena_regrant");

        // Asynchronous reset in the middle of CONNECT.
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.push_back(mk(4'b0, 6'b0, 0, 0, 0));
        name_q.push_back("rst_async");
        @(negedge clk);
        #1;
        rst        = 1'b0;
        req        = 4'b0001;
        settle_cyc = 8'd0;
        dead_cyc   = 4'd0;
        step(mk(4'b0001, 6'b000001, 0, 1, 0), "rst_first");
        step(mk(4'b0001, 6'b000001, 1, 1, 0), "rst_act");
        req = 4'b0000;
        step(mk(4'b0, 6'b0, 0, 1, 0), "rst_brk");
        step(mk(4'b0, 6'b0, 0, 0, 0), "rst_idle");

        // req[1] toggles 1->0->1 with zero dead time.
        req = 4'b0010;
        grant(1, 6'b000010, 0, 0, 1, 1'b0, 1'b1, "flap");
        step(mk(4'b0010, 6'b000010, 0, 1, 0), "flap_regrant");
        req = 4'b0000;
        step(mk(4'b0, 6'b0, 0, 1, 0), "flap_brk");
        step(mk(4'b0, 6'b0, 0, 0, 0), "flap_idle");

        // Drain the scoreboard with a bound.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
